// File: rtl/pid_error_if.sv
// pid_error_if: sample-in / term-out bus of the PID error front end.
// The slave modport is the pid_error stage. The master modport is the side that
// supplies samples and consumes the three terms (the summation stage, or a bench).
interface pid_error_if #(
   parameter int ADC_WIDTH = 13
);
   logic                     sample_valid;
   logic [ADC_WIDTH-1:0]     adc_data;
   logic [ADC_WIDTH-1:0]     setpoint;
   logic                     sum_rdy;
   logic [ADC_WIDTH-1:0]     proportional;
   logic [ADC_WIDTH-1:0]     derivative;
   logic [2*ADC_WIDTH-1:0]   integral;
   logic                     sum_en;

   modport master (
      output sample_valid, adc_data, setpoint, sum_rdy,
      input  proportional, derivative, integral, sum_en
   );

   modport slave (
      input  sample_valid, adc_data, setpoint, sum_rdy,
      output proportional, derivative, integral, sum_en
   );
endinterface

// File: rtl/pid_error.sv
// pid_error: PID front end. For each ADC sample it forms the proportional error,
// the first difference of that error and a clamped running integral. It holds the
// terms for the summation stage and starts that stage with a one-cycle sum_en.
// Optional macro PID_ERR_INT_HOLD_EN adds the int_hold anti-windup freeze input.
module pid_error #(
   parameter int ADC_WIDTH = 13,
   parameter int INT_LIMIT = 2**(2*ADC_WIDTH-1)-1
) (
   input  logic           clk,
   input  logic           n_rst,
   pid_error_if.slave     bus,
`ifdef PID_ERR_INT_HOLD_EN
   input  logic           int_hold,
`endif
   input  logic           ovr_clr,
   output logic           busy,
   output logic           overrun
);

   localparam int W   = ADC_WIDTH;
   localparam int IW  = 2*ADC_WIDTH;
   localparam int WP  = W + 1;
   localparam int IWP = IW + 1;

   // Symmetric limits. The most-negative code is excluded so that a downstream
   // ~x+1 negate can never overflow.
   localparam logic signed [W:0]  T_HI   = WP'((1 << (W-1)) - 1);
   localparam logic signed [W:0]  T_LO   = -T_HI;
   localparam logic signed [IW:0] INT_HI = IWP'(INT_LIMIT);
   localparam logic signed [IW:0] INT_LO = -INT_HI;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ERR,
      S_UPD,
      S_WAIT
   } state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    adc_q, adc_d;
   logic [W-1:0]    sp_q, sp_d;
   logic [W-1:0]    err_q, err_d;
   logic [W-1:0]    prev_q, prev_d;
   logic [W-1:0]    deriv_q, deriv_d;
   logic [IW-1:0]   int_q, int_d;
   logic [W-1:0]    prop_out_q, prop_out_d;
   logic [W-1:0]    der_out_q, der_out_d;
   logic [IW-1:0]   int_out_q, int_out_d;
   logic            sum_en_q, sum_en_d;
   logic            overrun_q, overrun_d;

   logic signed [W:0]  err_diff;
   logic signed [W:0]  der_diff;
   logic signed [IW:0] int_sum;

   function automatic logic [W-1:0] sat_w(input logic signed [W:0] x);
      if (x > T_HI)      return T_HI[W-1:0];
      else if (x < T_LO) return T_LO[W-1:0];
      else               return x[W-1:0];
   endfunction

   function automatic logic [IW-1:0] clamp_int(input logic signed [IW:0] x);
      if (x > INT_HI)      return INT_HI[IW-1:0];
      else if (x < INT_LO) return INT_LO[IW-1:0];
      else                 return x[IW-1:0];
   endfunction

   // Arithmetic carried one bit wider than its operands so the raw result never
   // wraps before it is saturated.
   always_comb begin
      err_diff = $signed({1'b0, sp_q}) - $signed({1'b0, adc_q});
      der_diff = $signed({err_q[W-1], err_q}) - $signed({prev_q[W-1], prev_q});
      int_sum  = $signed({int_q[IW-1], int_q}) + $signed({{(W+1){err_q[W-1]}}, err_q});
   end

   // Next-state and datapath control for the IDLE -> ERR -> UPD -> WAIT sequence.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can leave
      // one unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      adc_d      = adc_q;
      sp_d       = sp_q;
      err_d      = err_q;
      prev_d     = prev_q;
      deriv_d    = deriv_q;
      int_d      = int_q;
      prop_out_d = prop_out_q;
      der_out_d  = der_out_q;
      int_out_d  = int_out_q;
      sum_en_d   = 1'b0;
      overrun_d  = overrun_q;

      // A dropped sample takes priority over a clear on the same edge.
      if (ovr_clr)
         overrun_d = 1'b0;
      if (bus.sample_valid && (state_q != S_IDLE))
         overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (bus.sample_valid) begin
               adc_d   = bus.adc_data;
               sp_d    = bus.setpoint;
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            err_d   = sat_w(err_diff);
            state_d = S_UPD;
         end
         S_UPD: begin
            deriv_d = sat_w(der_diff);
`ifdef PID_ERR_INT_HOLD_EN
            if (!int_hold)
               int_d = clamp_int(int_sum);
`else
            int_d   = clamp_int(int_sum);
`endif
            prev_d  = err_q;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.sum_rdy) begin
               prop_out_d = err_q;
               der_out_d  = deriv_q;
               int_out_d  = int_q;
               sum_en_d   = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything, including the
   // integral and the derivative history.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         adc_q      <= '0;
         sp_q       <= '0;
         err_q      <= '0;
         prev_q     <= '0;
         deriv_q    <= '0;
         int_q      <= '0;
         prop_out_q <= '0;
         der_out_q  <= '0;
         int_out_q  <= '0;
         sum_en_q   <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample its _d value
         // from before the edge, independent of statement order.
         state_q    <= state_d;
         adc_q      <= adc_d;
         sp_q       <= sp_d;
         err_q      <= err_d;
         prev_q     <= prev_d;
         deriv_q    <= deriv_d;
         int_q      <= int_d;
         prop_out_q <= prop_out_d;
         der_out_q  <= der_out_d;
         int_out_q  <= int_out_d;
         sum_en_q   <= sum_en_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.proportional = prop_out_q;
   assign bus.derivative   = der_out_q;
   assign bus.integral     = int_out_q;
   assign bus.sum_en       = sum_en_q;
   assign busy             = (state_q != S_IDLE);
   assign overrun          = overrun_q;

endmodule

// File: doc/pid_error.md
Name: pid_error

Overview:
- Front-end stage of the PID controller, directly upstream of the PID summation stage.
- Takes each ADC sample strobe and computes the signed proportional error (setpoint − feedback), the first difference of that error, and a clamped running integral.
- Holds the three terms stable for the summation stage and fires a single-cycle sum_en when that stage reports sum_rdy.

Parameters:
- ADC_WIDTH, 13: width of ADC sample, setpoint, proportional and derivative terms.
- INT_LIMIT, 2**(2*ADC_WIDTH-1)-1: symmetric integral clamp magnitude. Must be ≤ 2**(2*ADC_WIDTH-1)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe; adc_data valid.
- adc_data  input  ADC_WIDTH  unsigned feedback sample.
- setpoint  input  ADC_WIDTH  unsigned target; sampled together with adc_data.
- sum_rdy  input  1  summation stage idle, may accept sum_en.
- ovr_clr  input  1  clears overrun.
- proportional  output  ADC_WIDTH  two's-complement error term.
- derivative  output  ADC_WIDTH  two's-complement error difference.
- integral  output  2*ADC_WIDTH  two's-complement integral term.
- sum_en  output  1  registered one-cycle start pulse to summation stage.
- busy  output  1  high in any state except IDLE.
- overrun  output  1  sticky: a sample was dropped.

Behaviour:
- Reset (async, n_rst=0): all state and outputs to 0; FSM to IDLE; prev_err=0; int_r=0.
- Symmetric saturation everywhere: W-bit terms clamp to ±(2**(W-1)-1). The most-negative code is never produced, so the downstream negate (~x+1) is always safe.

FSM:
- IDLE: on sample_valid, latch adc_data and setpoint into adc_r and sp_r → ERR.
- ERR: err_r = sat_W(sp_r − adc_r). Compute the difference in W+1 bits → UPD.
- UPD:
  - deriv_r = sat_W(err_r − prev_err), computed in W+1 bits.
  - int_r = clamp(int_r + sext(err_r), ±INT_LIMIT), computed in 2W+1 bits.
  - prev_err ← err_r.
  - → WAIT.
- WAIT:
  - While sum_rdy=0: hold. Outputs keep their previous values; sum_en stays 0.
  - When sum_rdy=1: on the same edge, load proportional←err_r, derivative←deriv_r, integral←int_r and set sum_en←1 → IDLE.
- sum_en is cleared on the next edge, so it is exactly one cycle wide.
- Outputs change only at the commit edge. They stay stable while the summation stage is busy.

Timing and flags:
- Latency: sample_valid sampled at edge N. With sum_rdy high, outputs update and sum_en rises at edge N+3. Minimum sample spacing is 4 cycles.
- First sample after reset: prev_err=0, so derivative = err.
- Overrun: sample_valid high while FSM ≠ IDLE → sample ignored, overrun←1. ovr_clr clears it; set wins if both occur on the same edge.
- busy = (state ≠ IDLE); combinational from the state register.
- Reset mid-operation: aborts immediately. No sum_en is issued and the integral is lost.

Optional Feature:
- Macro PID_ERR_INT_HOLD_EN.
- Defined: adds input int_hold (1 bit), the anti-windup freeze driven by the output stage. When int_hold=1 in UPD, int_r is left unchanged; derivative and prev_err still update.
- Undefined: the port is absent and the integral always accumulates.

Test Plan:
- Basic, after reset: setpoint=4000, adc=3900, sum_rdy=1 → 3 edges later proportional=100, derivative=100, integral=100, sum_en high exactly 1 cycle.
- Second sample: setpoint=4000, adc=3950 → proportional=50, derivative=−50 (0x1FCE), integral=150.
- Saturation:
  - setpoint=8191, adc=0 → proportional=4095 (0x0FFF).
  - Then setpoint=0, adc=8191 → proportional=−4095 (0x1001), derivative=−4095 (raw −8190 clamped).
- Integral clamp with INT_LIMIT=1000: five samples of err=300 → integral 300, 600, 900, 1000, 1000; negative run clamps at −1000.
- Backpressure: hold sum_rdy=0 → FSM waits in WAIT, outputs unchanged, sum_en=0; raise sum_rdy → commit and sum_en on that edge.
- Overrun and reset:
  - sample_valid pulsed while busy → overrun=1 and the sample is not used; ovr_clr → overrun=0.
  - n_rst low mid-UPD → all outputs 0 at once, no sum_en.
